// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a prefetch FIFO, and redirect handling that drains stale responses.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [31:0]             fetch_pc, rsp_pc, target;
  logic [CW-1:0]           outstanding, outstanding_nx, count, drop_count, drop_nx;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [DEPTH-1:0][31:0]  pc_q, instr_q;
  logic [CW:0]             inflight;
  logic                    accept, push, pop, redir;

  // Buffer entries plus requests in flight never exceed DEPTH, so a push always has room.
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = (state == FETCH) && (inflight < LIMIT);
  assign imem_req_addr  = fetch_pc;

  assign accept = imem_req_valid && imem_req_ready;
  assign redir  = redirect_valid && (state != IDLE);
  assign push   = imem_rsp_valid && (state == FETCH) && !redir;
  assign pop    = out_valid && out_ready;
  assign target = {redirect_pc[31:2], 2'b00};

  assign outstanding_nx = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  assign out_valid = (count != '0);
  assign out_pc    = pc_q[rd_ptr];
  assign out_instr = instr_q[rd_ptr];

  always_comb begin
    state_nx = state;
    drop_nx  = drop_count;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: state_nx = FETCH;
      DRAIN: if (imem_rsp_valid) begin
        drop_nx = drop_count - CW'(1);
        if (drop_count == CW'(1)) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
    // Stale responses still in flight (including one issued this cycle) must be skipped.
    if (redir) begin
      drop_nx  = outstanding_nx;
      state_nx = (outstanding_nx != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
    end else begin
      state       <= state_nx;
      drop_count  <= drop_nx;
      outstanding <= outstanding_nx;
      if (redir)       fetch_pc <= target;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (redir)     rsp_pc <= target;
      else if (push) rsp_pc <= rsp_pc + 32'd4;
      if (redir) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr]    <= rsp_pc;
          instr_q[wr_ptr] <= imem_rsp_data;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
